mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the processor's single-ported unified memory between the fetch stage (I-port) and the memory stage (D-port). Each transaction is sequenced through a fixed issue/wait/respond FSM. Data accesses have priority, bounded by a fairness counter so fetch cannot starve. The block sits between the fetch and memory stages and the memory model. It exposes a per-port done pulse plus idle and error status for the testbench.

## Interface
- `TIMEOUT`, default 16: maximum number of WAIT cycles allowed before a memory transaction is aborted.
- `MAX_D_STREAK`, default 4: number of consecutive D grants allowed while `i_req` is pending before I is forced.
- `clk`  in  1  system clock; one clock domain, all logic on posedge.
- `rst`  in  1  reset; asynchronous, active-low.
- `i_req`  in  1  fetch request; held until `i_done`.
- `i_addr`  in  16  fetch address; stable while `i_req` is high.
- `i_done`  out  1  one-cycle pulse; `i_rdata` is valid in the same cycle.
- `i_rdata`  out  16  fetched instruction word, registered.
- `d_req`  in  1  data request; held until `d_done`.
- `d_wr`  in  1  1 = store, 0 = load.
- `d_addr`  in  16  data address.
- `d_wdata`  in  16  store data.
- `d_done`  out  1  one-cycle pulse.
- `d_rdata`  out  16  load data, registered; updated on loads only.
- `mem_en`  out  1  one-cycle memory command strobe.
- `mem_wr`  out  1  write qualifier for `mem_en`.
- `mem_addr`  out  16  registered address; held from ISSUE through RESP.
- `mem_wdata`  out  16  registered write data; held like `mem_addr`.
- `mem_rdata`  in  16  read data; valid when `mem_done` is high.
- `mem_done`  in  1  memory completion; sampled only in WAIT.
- `halt`  in  1  processor halted; blocks new I grants.
- `idle`  out  1  high when the FSM is in IDLE.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Owner register `own` records the granted port (I or D).
- IDLE:
  - Candidates are `d_req`, and `i_req & ~halt`.
  - If only one candidate is present, grant it.
  - If both are present, grant D, unless `d_streak == MAX_D_STREAK`; in that case grant I.
  - On grant: latch addr/wdata/wr (fetch uses `wr = 0`), set `own`, go to ISSUE.
  - If there is no candidate, stay in IDLE.
- ISSUE: `mem_en = 1` and `mem_wr` = latched wr for exactly this cycle. Clear `wait_cnt`. Go to WAIT.
- WAIT:
  - If `mem_done` is high: capture `mem_rdata` into the owner's rdata register (D: loads only), then go to RESP.
  - Otherwise increment `wait_cnt`.
  - When `wait_cnt` reaches `TIMEOUT - 1` without `mem_done`: set `err`, load `16'hFFFF` into the owner's rdata (D: loads only), then go to RESP.
- RESP: the owner's done signal is 1 for this cycle. Always go to IDLE.
- `d_streak` update rules:
  - On a D grant while `i_req` is high: increment, saturating at `MAX_D_STREAK`.
  - On an I grant: clear to 0.
  - On a D grant while `i_req` is low: clear to 0.
- Requesters drop `req` or present a new request in the cycle after done. Because RESP always returns to IDLE, a held `req` is treated as a new request.
- `halt` only gates I arbitration. An I transaction already in flight completes normally.
- `mem_done` outside WAIT is ignored.

## Timing
- Reset values (async assert):
  - State IDLE, `idle = 1`.
  - `i_done`, `d_done`, `mem_en`, `mem_wr`, `err` = 0.
  - `i_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` = 0.
  - `d_streak` and `wait_cnt` = 0.
- Reset asserted mid-transaction aborts the transaction with no done pulse; reset deassertion takes effect on the next `clk` edge.
- Best case: with `req` high in cycle 0 and `mem_done` in cycle 2, ISSUE is cycle 1, WAIT is cycle 2, and done is in cycle 3. Throughput is then one transaction per 4 cycles.
- Each extra memory wait cycle adds one cycle of latency.
- On timeout, done comes `TIMEOUT + 2` cycles after the request (16 WAIT cycles for `TIMEOUT = 16`).
- `mem_addr`, `mem_wdata` and `mem_wr` stay stable from ISSUE through RESP.

## Test plan
- Single fetch: `i_req`, `i_addr = 0x0010`; memory returns `0xC001` in cycle 2. Required: `mem_en` in cycle 1 with `mem_addr = 0x0010`, `mem_wr = 0`; `i_done` in cycle 3 with `i_rdata = 0xC001`; `idle = 1` again in cycle 4.
- Simultaneous requests: `i_req` (addr `0x0020`) and `d_req` load (addr `0x0200`) in the same cycle. Required: D is served first (`d_done` in cycle 3), then the I issue appears in cycle 5 with `i_done` in cycle 7.
- Fairness: `d_req` held continuously with `i_req` pending. Required: exactly 4 D transactions, then 1 I transaction, then D resumes with `d_streak = 0`.
- Store: `d_wr = 1`, `d_addr = 0x0100`, `d_wdata = 0xBEEF`. Required: `mem_wr = 1`, `mem_wdata = 0xBEEF`, `d_done` pulses, `d_rdata` keeps its prior value.
- Timeout: a D load where memory never asserts `mem_done`. Required: after 16 WAIT cycles, `err = 1` and `d_done` with `d_rdata = 0xFFFF`; `err` stays 1 across later good transactions.
- Halt and reset:
  - With `halt = 1` and `i_req` held: no I grant, `idle` stays 1, and D still completes.
  - `rst` low in WAIT: all outputs return immediately to their reset values, with no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for the single-ported unified memory shared by fetch (I) and data (D).
// Every transaction runs the same issue/wait/respond sequence; D wins ties, bounded by a streak counter.
//
// state | meaning
// IDLE  | no transaction; arbitrate between d_req and i_req & ~halt
// ISSUE | one-cycle mem_en strobe, wait counter cleared
// WAIT  | waiting for mem_done or for the timeout to expire
// RESP  | owner's done pulse; always returns to IDLE
module mem_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        halt,
  output logic        idle,
  output logic        err
);

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          own_d;
  logic [SW-1:0] d_streak;
  logic [WW-1:0] wait_cnt;

  logic i_cand;
  logic grant_d;
  logic grant_i;

  // D loses a tie only once it has used up its streak allowance
  assign i_cand  = i_req & ~halt;
  assign grant_d = d_req & (~i_cand | (d_streak != STREAK_MAX));
  assign grant_i = i_cand & ~grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      own_d     <= 1'b0;
      d_streak  <= '0;
      wait_cnt  <= '0;
      idle      <= 1'b1;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= ISSUE;
            idle      <= 1'b0;
            mem_en    <= 1'b1;
            own_d     <= 1'b1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wr    <= d_wr;
            if (!i_req)
              d_streak <= '0;
            else if (d_streak != STREAK_MAX)
              d_streak <= d_streak + SW'(1);
          end else if (grant_i) begin
            state     <= ISSUE;
            idle      <= 1'b0;
            mem_en    <= 1'b1;
            own_d     <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            d_streak  <= '0;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            state <= RESP;
            if (own_d) begin
              d_done <= 1'b1;
              if (!mem_wr) d_rdata <= mem_rdata;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state <= RESP;
            err   <= 1'b1;
            if (own_d) begin
              d_done <= 1'b1;
              if (!mem_wr) d_rdata <= 16'hFFFF;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= 16'hFFFF;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule
